arbitro_calculadora: RTL
========================

# arbitro_calculadora

Round-robin arbiter and sequencer that shares one `calculadora` instance (8-bit, 3-bit `codigo`) between two requesters. Each requester presents an operation through a valid/ready handshake. The block latches the winning request's operands and code, runs them through the shared `calculadora` for one cycle, registers the result, and returns it to the winning requester through a valid/ready response handshake. It sits between the two front-end command sources and the combinational calculator datapath.

## Interface
- Parameters: none (datapath fixed at 8 bits, code at 3 bits, matching `calculadora`).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`, `req1_valid`  in  1 each  request pending from requester 0 / 1.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle.
- `req0_A`, `req0_B`, `req1_A`, `req1_B`  in  8 each  operands.
- `req0_codigo`, `req1_codigo`  in  3 each  operation code: 000 zero, 001 A, 010 B, 011 A+B, 100 A−B, 101–111 zero.
- `resp0_valid`, `resp1_valid`  out  1 each  result available for requester 0 / 1.
- `resp0_ready`, `resp1_ready`  in  1 each  requester consumes the result.
- `resp_saida`  out  8  result, shared by both response ports and meaningful only while a `respN_valid` is high.
- `ocupado`  out  1  high whenever state ≠ OCIOSO.

## Operation
- FSM states: OCIOSO → EXECUTA → RESPONDE → OCIOSO.
- OCIOSO:
  - Grant: if exactly one `reqN_valid` is high, that port wins. If both are high, the port not recorded in `ultimo` wins.
  - `reqN_ready` = (state == OCIOSO) and grant == N. It is combinational from the valids, and at most one ready is high.
  - On the handshake (valid and ready at an edge): latch A, B, `codigo` and the winner index into internal registers, then go to EXECUTA.
  - With no valid request, stay in OCIOSO.
- EXECUTA:
  - The `calculadora` inputs are driven only from the latched registers, never directly from the request ports.
  - At the next edge, capture `saida` into `resp_saida` and go to RESPONDE.
- RESPONDE:
  - `respN_valid` is high for the latched winner only.
  - Hold state and `resp_saida` until `respN_ready` is high at an edge. On that edge, update `ultimo` to the winner and return to OCIOSO.
- Arithmetic: modulo 256, no carry or borrow output. 200+100 = 44; 5−10 = 251.
- Requesters must hold `reqN_valid` and their operands stable until ready. Behaviour if a requester withdraws its request is undefined.
- Request-port inputs that change after acceptance do not affect the result in flight.

## Timing
- Reset values (asynchronous, while `rst_n` is low):
  - state = OCIOSO, `ultimo` = 1 (port 0 wins the first tie).
  - `resp_saida` = 0, latched operand and code registers = 0.
  - All `respN_valid` = 0, `ocupado` = 0.
  - `reqN_ready` is 0 while reset is asserted.
- Latency: handshake at edge N; `respN_valid` high from edge N+2. With `respN_ready` already high, the response completes at edge N+2 and a new request can be accepted at edge N+3. Peak throughput is therefore one operation per 3 cycles.
- `respN_ready` while the corresponding `respN_valid` is low: ignored.
- Back-to-back requests on both ports: grants strictly alternate 0,1,0,1…
- Reset asserted in EXECUTA or RESPONDE: the transaction is dropped silently and no response is issued after reset release.

## Test plan
- Reset: after `rst_n` low then high, all outputs are 0 and the state is OCIOSO. Then `req0` with A=200, B=100, `codigo`=011 → `req0_ready` high in the same cycle, `resp0_valid` high 2 edges later with `resp_saida`=44.
- Subtraction wrap: `req1` with A=5, B=10, `codigo`=100 → `resp1_valid` with 251. `resp0_valid` stays 0 throughout.
- Tie and fairness: both valid continuously, with `req0` = (7, 3, 011) and `req1` = (7, 3, 100) → responses in port order 0,1,0,1 with results 10,4,10,4.
- Backpressure: hold `resp0_ready` low for 5 cycles → `resp0_valid`, `resp_saida` and `ocupado` stay stable and `req1_ready` stays 0. Raising `resp0_ready` completes the response, and OCIOSO follows.
- Codes: `codigo` 000/001/010/101/111 with A=0x5A, B=0xA5 → results 0x00 / 0x5A / 0xA5 / 0x00 / 0x00 respectively.
- Mid-operation reset: pulse `rst_n` low during EXECUTA → no `respN_valid` ever appears for that request. The next request completes normally, and port 0 wins the tie.

Source files
------------

// File: rtl/arbitro_calculadora_if.sv
// Request/response bundle between two command sources and the shared calculator arbiter.
// Carries two valid/ready request channels, two valid/ready response channels, shared result.
// Signal-only interface: no logic, no clocking.
interface arbitro_calculadora_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_A;
  logic [7:0] req0_B;
  logic [2:0] req0_codigo;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_A;
  logic [7:0] req1_B;
  logic [2:0] req1_codigo;
  logic       resp0_valid;
  logic       resp0_ready;
  logic       resp1_valid;
  logic       resp1_ready;
  logic [7:0] resp_saida;
  logic       ocupado;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_A, req0_B, req0_codigo,
    input  req1_valid, req1_A, req1_B, req1_codigo,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_saida, ocupado
  );

  // Requester side
  modport master (
    output req0_valid, req0_A, req0_B, req0_codigo,
    output req1_valid, req1_A, req1_B, req1_codigo,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_saida, ocupado
  );
endinterface

// File: rtl/arbitro_calculadora.sv
// Round-robin arbiter sharing one 8-bit calculator between two requesters.
// Latency: accept at edge N, result registered at N+1, response seen at N+2; one op per 3 cycles.
// Backpressure: response held until respN_ready; no request accepted while busy.

// Combinational 8-bit calculator, arithmetic modulo 256.
module calculadora (
  input  logic [7:0] A_i,
  input  logic [7:0] B_i,
  input  logic [2:0] codigo_i,
  output logic [7:0] saida_o
);
  // Operation decode
  always_comb begin
    saida_o = 8'd0;
    case (codigo_i)
      3'b001:  saida_o = A_i;
      3'b010:  saida_o = B_i;
      3'b011:  saida_o = A_i + B_i;
      3'b100:  saida_o = A_i - B_i;
      default: saida_o = 8'd0;
    endcase
  end
endmodule

module arbitro_calculadora (
  input  logic                   clk,
  input  logic                   rst_n,
  arbitro_calculadora_if.slave   bus
);
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  estado_t    estado_q, estado_d;
  logic       ultimo_q, ultimo_d;   // port served most recently; loses the next tie
  logic       venc_q;               // winner of the transaction in flight
  logic [7:0] a_q, b_q;
  logic [2:0] cod_q;
  logic [7:0] saida_q;

  logic       grant_vld;
  logic       grant;
  logic       aceita;
  logic       resp_rdy_sel;
  logic [7:0] calc_saida;

  // Grant: single requester wins outright, a tie goes to the port not served last
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    grant     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~ultimo_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held
  assign bus.req0_ready = rst_n && (estado_q == OCIOSO) && grant_vld && !grant;
  assign bus.req1_ready = rst_n && (estado_q == OCIOSO) && grant_vld &&  grant;

  assign aceita       = (estado_q == OCIOSO) && grant_vld;
  assign resp_rdy_sel = venc_q ? bus.resp1_ready : bus.resp0_ready;

  assign bus.resp0_valid = (estado_q == RESPONDE) && !venc_q;
  assign bus.resp1_valid = (estado_q == RESPONDE) &&  venc_q;
  assign bus.resp_saida  = saida_q;
  assign bus.ocupado     = (estado_q != OCIOSO);

  // Calculator sees only latched operands, never the live request ports
  calculadora u_calc (
    .A_i      (a_q),
    .B_i      (b_q),
    .codigo_i (cod_q),
    .saida_o  (calc_saida)
  );

  // Next-state and fairness pointer update
  always_comb begin
    estado_d = estado_q;
    ultimo_d = ultimo_q;
    case (estado_q)
      OCIOSO: begin
        if (aceita) estado_d = EXECUTA;
      end
      EXECUTA: begin
        estado_d = RESPONDE;
      end
      RESPONDE: begin
        if (resp_rdy_sel) begin
          estado_d = OCIOSO;
          ultimo_d = venc_q;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State register; ultimo resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      ultimo_q <= 1'b1;
    end else begin
      estado_q <= estado_d;
      ultimo_q <= ultimo_d;
    end
  end

  // Operand latch on accept, result capture at the end of EXECUTA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      venc_q  <= 1'b0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      cod_q   <= 3'd0;
      saida_q <= 8'd0;
    end else begin
      if (aceita) begin
        venc_q <= grant;
        a_q    <= grant ? bus.req1_A      : bus.req0_A;
        b_q    <= grant ? bus.req1_B      : bus.req0_B;
        cod_q  <= grant ? bus.req1_codigo : bus.req0_codigo;
      end
      if (estado_q == EXECUTA) begin
        saida_q <= calc_saida;
      end
    end
  end
endmodule
